// File: rtl/bird_motion_ctrl.sv
// Bird motion controller: synchronizes the flap key, times gravity and flap steps, and tracks the game state.
// Optional FLAP_AUTOREPEAT_EN: a held key keeps flapping with up steps FLAP_GAP apart.
module bird_motion_ctrl #(
    parameter int GRAVITY_PERIOD = 12_500_000,
    parameter int FLAP_STEPS     = 2,
    parameter int FLAP_GAP       = 4_000_000,
    parameter int CNT_W          = 24
) (
    input  logic Clock,
    input  logic RST,
    input  logic key_n,
    input  logic start,
    input  logic crash,
    output logic up,
    output logic down,
    output logic running
);

    localparam int SW = (FLAP_STEPS > 1) ? $clog2(FLAP_STEPS) : 1;
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(FLAP_GAP - 1);
    localparam logic [SW-1:0]    STEPS_RELOAD = SW'(FLAP_STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLAP, DEAD} state_t;

    state_t           state, state_d;
    logic             sync1, sync2, key_prev;
    logic             press, held;
    logic [CNT_W-1:0] grav, grav_d, gap, gap_d;
    logic [SW-1:0]    steps, steps_d;
    logic             up_d, down_d, running_d;

    // Synchronizer idles at 1 so reset never looks like a press.
    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            key_prev <= sync2;
        end
    end

    assign press = key_prev & ~sync2;
`ifdef FLAP_AUTOREPEAT_EN
    assign held = ~sync2;
`else
    assign held = 1'b0;
`endif

    always_comb begin
        state_d = state;
        grav_d  = grav;
        gap_d   = gap;
        steps_d = steps;
        up_d    = 1'b0;
        down_d  = 1'b0;
        case (state)
            IDLE: begin
                grav_d = '0;
                gap_d  = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (crash) begin
                    state_d = DEAD;
                    grav_d  = '0;
                end else if (press) begin
                    state_d = FLAP;
                    up_d    = 1'b1;
                    steps_d = STEPS_RELOAD;
                    gap_d   = '0;
                    grav_d  = '0;
                end else if (grav == GRAV_LAST) begin
                    down_d = 1'b1;
                    grav_d = '0;
                end else begin
                    grav_d = grav + 1'b1;
                end
            end
            FLAP: begin
                grav_d = '0;
                if (crash) begin
                    state_d = DEAD;
                    gap_d   = '0;
                end else if (press) begin
                    up_d    = 1'b1;
                    steps_d = STEPS_RELOAD;
                    gap_d   = '0;
                end else if (steps == '0 && !held) begin
                    state_d = RUN;
                    gap_d   = '0;
                end else if (gap == GAP_LAST) begin
                    // With steps exhausted and the key held, keep the same cadence and reload.
                    up_d    = 1'b1;
                    gap_d   = '0;
                    steps_d = (steps == '0) ? STEPS_RELOAD : steps - 1'b1;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end
            DEAD: begin
                grav_d = '0;
                gap_d  = '0;
                if (start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN) || (state_d == FLAP);
    end

    always_ff @(posedge Clock or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            grav    <= '0;
            gap     <= '0;
            steps   <= '0;
            up      <= 1'b0;
            down    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_d;
            grav    <= grav_d;
            gap     <= gap_d;
            steps   <= steps_d;
            up      <= up_d;
            down    <= down_d;
            running <= running_d;
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Self-checking bench for bird_motion_ctrl: vector table, directed corner sequences and random run vs deadline model.
module tb_bird_motion_ctrl;

    localparam int P = 8;
    localparam int S = 2;
    localparam int G = 3;

    logic Clock = 1'b0;
    logic RST   = 1'b0;
    logic key_n = 1'b1;
    logic start = 1'b0;
    logic crash = 1'b0;
    logic up, down, running;

    bird_motion_ctrl #(.GRAVITY_PERIOD(P), .FLAP_STEPS(S), .FLAP_GAP(G), .CNT_W(4)) dut (
        .Clock(Clock), .RST(RST), .key_n(key_n), .start(start), .crash(crash),
        .up(up), .down(down), .running(running)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int up_cnt = 0;
    int down_cnt = 0;
    int m_up_cnt = 0;

    // Reference model: game mode plus absolute cycle deadlines for the next down / next up.
    int   n;
    int   m_mode;             // 0 idle, 1 run, 2 flap, 3 dead
    int   next_down, next_up, pending;
    logic h1, h2, h3;         // key samples from 1, 2 and 3 edges ago
    logic m_up, m_down, m_run;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_mode = 0; n = 0;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
        m_up = 1'b0; m_down = 1'b0; m_run = 1'b0;
    endfunction

    function automatic void m_step(input logic k, input logic st, input logic cr);
        logic pr, hd;
        pr = h3 & ~h2;
`ifdef FLAP_AUTOREPEAT_EN
        hd = ~h2;
`else
        hd = 1'b0;
`endif
        m_up = 1'b0;
        m_down = 1'b0;
        case (m_mode)
            0: if (st) begin m_mode = 1; next_down = n + P; end
            1: begin
                if (cr) m_mode = 3;
                else if (pr) begin m_up = 1'b1; m_mode = 2; pending = S - 1; next_up = n + G; end
                else if (n == next_down) begin m_down = 1'b1; next_down = n + P; end
            end
            2: begin
                if (cr) m_mode = 3;
                else if (pr) begin m_up = 1'b1; pending = S - 1; next_up = n + G; end
                else if (pending == 0 && !hd) begin m_mode = 1; next_down = n + P; end
                else if (n == next_up) begin
                    m_up = 1'b1;
                    pending = (pending == 0) ? S - 1 : pending - 1;
                    next_up = n + G;
                end
            end
            default: if (st) m_mode = 0;
        endcase
        m_run = (m_mode == 1 || m_mode == 2);
        if (m_up) m_up_cnt++;
        h3 = h2; h2 = h1; h1 = k;
        n++;
    endfunction

    task automatic tick(input logic k, input logic st, input logic cr);
        key_n = k; start = st; crash = cr;
        @(posedge Clock);
        m_step(k, st, cr);
        @(negedge Clock);
        if (up) up_cnt++;
        if (down) down_cnt++;
        chk("up", up, m_up);
        chk("down", down, m_down);
        chk("running", running, m_run);
        if (up && down) chk("up_down_exclusive", 1, 0);
    endtask

    typedef struct {
        logic k, st, cr;
        logic eu, ed, er;
    } vec_t;
    vec_t tbl[46];

    initial begin
        // Vectors from a start pulse: downs every P, a one-sample press landing on a gravity tick.
        for (int i = 0; i < 46; i++)
            tbl[i] = '{k: 1'b1, st: (i == 0), cr: 1'b0, eu: 1'b0, ed: 1'b0, er: 1'b1};
        tbl[8].ed  = 1'b1;
        tbl[16].ed = 1'b1;
        tbl[24].ed = 1'b1;
        tbl[30].k  = 1'b0;
        tbl[32].eu = 1'b1;
        tbl[35].eu = 1'b1;
        tbl[44].ed = 1'b1;

        m_reset();
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("reset_up", up, 0);
        chk("reset_down", down, 0);
        chk("reset_running", running, 0);
        RST = 1'b1;
        m_reset();

        for (int i = 0; i < 46; i++) begin
            tick(tbl[i].k, tbl[i].st, tbl[i].cr);
            chk("tbl_up", up, tbl[i].eu);
            chk("tbl_down", down, tbl[i].ed);
            chk("tbl_running", running, tbl[i].er);
        end

        // Re-press during a flap: press, re-press two cycles later, three ups in all.
        up_cnt = 0; down_cnt = 0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (9) tick(1'b1, 1'b0, 1'b0);
        chk("repress_ups", up_cnt, 3);
        chk("repress_downs", down_cnt, 0);

        // Key held low for 20 cycles.
        up_cnt = 0; down_cnt = 0; m_up_cnt = 0;
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        repeat (20) tick(1'b1, 1'b0, 1'b0);
`ifdef FLAP_AUTOREPEAT_EN
        chk("held_ups", up_cnt, m_up_cnt);
`else
        chk("held_ups", up_cnt, 2);
        chk("held_downs", down_cnt, 4);
`endif

        // Crash on the edge a gravity tick is due.
        for (int w = 0; w < 20 && !(m_mode == 1 && next_down == n); w++)
            tick(1'b1, 1'b0, 1'b0);
        if (!(m_mode == 1 && next_down == n)) chk("crash_align_timeout", 0, 1);
        tick(1'b1, 1'b0, 1'b1);
        chk("crash_down", down, 0);
        chk("crash_running", running, 0);
        up_cnt = 0;
        tick(1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        chk("dead_ups", up_cnt, 0);
        tick(1'b1, 1'b1, 1'b0);
        chk("dead_start_idle", running, 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("second_start_run", running, 1);

        // Asynchronous reset while up is high.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("pre_reset_up", up, 1);
        #1 RST = 1'b0;
        #1;
        chk("async_up", up, 0);
        chk("async_down", down, 0);
        chk("async_running", running, 0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        RST = 1'b1;
        m_reset();
        up_cnt = 0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0, 1'b0);
        chk("idle_press_ups", up_cnt, 0);
        chk("idle_running", running, 0);

        // Random stimulus against the model.
        begin
            logic kr;
            kr = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 4) == 0) kr = ~kr;
                tick(kr, ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
